button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Multi-channel button/controller front end. Successor to the single-bit one-shot press detector.
- Per channel: synchronises the raw input, debounces it, and produces a debounced level, a one-cycle press pulse and a one-cycle release pulse.
- Optional per-channel typematic auto-repeat (held D-pad scrolls menus, held run button).
- Sits between board pins/controller decoder and game logic, entirely in the vga_clock domain.

Parameters:
- CHANNELS, 4, number of independent input channels.
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- DEBOUNCE_CYCLES, 250000, consecutive mismatching cycles needed to flip the level (>=1; 10 ms at 25 MHz).
- REPEAT_DELAY, 12500000, cycles from the initial press pulse to the first repeat pulse (>=2).
- REPEAT_RATE, 2500000, cycles between subsequent repeat pulses (>=2).

Ports:
- vga_clock  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- signal  in  CHANNELS  raw asynchronous button inputs, 1 = pushed.
- repeat_en  in  CHANNELS  per-channel auto-repeat enable, sampled every cycle.
- level  out  CHANNELS  debounced button state.
- pressed  out  CHANNELS  one-cycle pulse on press and on each auto-repeat.
- released  out  CHANNELS  one-cycle pulse on release.

Behaviour:
- Reset (synchronous, active-high, dominates everything): sync flops, level, pressed, released, all counters = 0; every repeat FSM = IDLE. All outputs are registered.
- Sync: sync_q[i] = signal[i] after SYNC_STAGES flops.
- Debounce (per channel, counter width $clog2(DEBOUNCE_CYCLES+1)):
  - If sync_q == level, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1, then level <= sync_q and cnt <= 0.
  - Else cnt <= cnt+1.
  - Any single matching cycle restarts the count, so glitches shorter than DEBOUNCE_CYCLES never reach level.
- Latency: if signal is stable from before edge 1, level changes at edge SYNC_STAGES+DEBOUNCE_CYCLES.
- Pulses:
  - pressed[i] = 1 on the same edge level rises, for exactly one cycle.
  - released[i] = 1 on the same edge level falls, for exactly one cycle.
  - pressed and released are never both high on the same channel.
- Repeat FSM (per channel, counter hcnt width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1)):
  - IDLE: on level rise, pulse pressed, hcnt <= 0, go to DELAY if repeat_en[i] else HOLD.
  - DELAY: hcnt++. When hcnt == REPEAT_DELAY-1: pulse pressed, hcnt <= 0, go to REPEAT. First repeat lands exactly REPEAT_DELAY cycles after the initial pulse.
  - REPEAT: hcnt++. When hcnt == REPEAT_RATE-1: pulse pressed, hcnt <= 0. Pulses are exactly REPEAT_RATE cycles apart.
  - HOLD: no pulses; wait for release.
  - repeat_en[i] = 0 while in DELAY or REPEAT: go to HOLD next edge with no pulse that cycle. Re-asserting repeat_en does not resume repeats until the next press.
  - Level fall from any state: pulse released, go to IDLE, hcnt <= 0. Release wins over a coincident repeat pulse.
- Channels are fully independent; simultaneous events on different channels are each reported in the same cycle.
- Reset mid-press: after reset deasserts with signal still high, the full sync+debounce latency elapses, then a fresh pressed pulse is issued.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, CHANNELS=4):
1. Hold reset 3 cycles with signal=4'hF. All outputs must read 0 throughout; release reset with signal=4'hF. Then level=4'hF and pressed=4'hF both rise at edge 6 after reset deassertion; pressed is high for that one cycle only.
2. Glitch: signal[0] high for 3 cycles, then low. level[0], pressed[0] and released[0] stay 0 for the next 20 cycles.
3. Press/release ch1 with repeat_en=0: signal[1] high 20 cycles, then low. Expect a pressed[1] pulse at edge 6 with no further pulses, then a released[1] pulse exactly 6 edges after the falling input edge.
4. Auto-repeat ch2 (repeat_en[2]=1, held 30 cycles): initial press pulse at edge P. Repeat pulses at P+10, P+13, P+16, … until release. On release, released[2] pulses and no pressed pulse coincides.
5. Mid-hold disable: ch3 held with repeat_en[3]=1; drop repeat_en[3] at P+11. No pulse at P+13 or later; released[3] still pulses on release.
6. Concurrency: press ch0 and ch2 on the same edge while ch1 releases. Expect pressed=4'b0101 and released=4'b0010 in the same cycle.

Source files
------------

// File: rtl/button_conditioner.sv
// Multi-channel button front end: synchroniser, debouncer, press/release pulses and an optional
// typematic auto-repeat per channel, all in the vga_clock domain.
module button_conditioner #(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_RATE     = 2500000
) (
    input  logic                vga_clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] signal,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] released
);

    localparam int unsigned DebW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HoldMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned HoldW   = $clog2(HoldMax + 1);

    localparam logic [DebW-1:0]  DebLast   = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] DelayLast = HoldW'(REPEAT_DELAY - 1);
    localparam logic [HoldW-1:0] RateLast  = HoldW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat, StHold} rpt_state_e;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync;
        logic [DebW-1:0]        cnt_q, cnt_d;
        logic                   level_q, level_d;
        logic                   rise, fall;
        rpt_state_e             state_q, state_d;
        logic [HoldW-1:0]       hcnt_q, hcnt_d;
        logic                   pressed_q, pressed_d;
        logic                   released_q, released_d;

        assign sync = sync_q[SYNC_STAGES-1];

        // Any matching sample restarts the count, so short glitches never flip the level.
        always_comb begin
            cnt_d   = cnt_q;
            level_d = level_q;
            rise    = 1'b0;
            fall    = 1'b0;
            if (sync == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == DebLast) begin
                level_d = sync;
                cnt_d   = '0;
                rise    = sync;
                fall    = ~sync;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_comb begin
            state_d = state_q;
            if (fall) begin
                state_d = StIdle;
            end else begin
                case (state_q)
                    StIdle:   if (rise) state_d = repeat_en[i] ? StDelay : StHold;
                    StDelay: begin
                        if (!repeat_en[i])            state_d = StHold;
                        else if (hcnt_q == DelayLast) state_d = StRepeat;
                    end
                    StRepeat: if (!repeat_en[i]) state_d = StHold;
                    StHold:   state_d = StHold;
                    default:  state_d = StIdle;
                endcase
            end
        end

        // A release suppresses any repeat pulse due on the same edge.
        always_comb begin
            pressed_d  = 1'b0;
            released_d = fall;
            hcnt_d     = '0;
            if (!fall) begin
                case (state_q)
                    StIdle: pressed_d = rise;
                    StDelay: begin
                        if (repeat_en[i]) begin
                            if (hcnt_q == DelayLast) pressed_d = 1'b1;
                            else                     hcnt_d    = hcnt_q + 1'b1;
                        end
                    end
                    StRepeat: begin
                        if (repeat_en[i]) begin
                            if (hcnt_q == RateLast) pressed_d = 1'b1;
                            else                    hcnt_d    = hcnt_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end

        always_ff @(posedge vga_clock) begin
            if (reset) begin
                sync_q     <= '0;
                cnt_q      <= '0;
                level_q    <= 1'b0;
                state_q    <= StIdle;
                hcnt_q     <= '0;
                pressed_q  <= 1'b0;
                released_q <= 1'b0;
            end else begin
                sync_q     <= {sync_q[SYNC_STAGES-2:0], signal[i]};
                cnt_q      <= cnt_d;
                level_q    <= level_d;
                state_q    <= state_d;
                hcnt_q     <= hcnt_d;
                pressed_q  <= pressed_d;
                released_q <= released_d;
            end
        end

        assign level[i]    = level_q;
        assign pressed[i]  = pressed_q;
        assign released[i] = released_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus randomized presses, all checked against
// a time-stamp based behavioural model of debounce and typematic repeat.
module tb_button_conditioner;

    localparam int unsigned CH  = 4;
    localparam int unsigned SS  = 2;
    localparam int unsigned DEB = 4;
    localparam int unsigned RD  = 10;
    localparam int unsigned RR  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] sig;
    logic [CH-1:0] ren;
    logic [CH-1:0] level;
    logic [CH-1:0] pressed;
    logic [CH-1:0] released;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .CHANNELS       (CH),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .vga_clock(clk),
        .reset    (rst),
        .signal   (sig),
        .repeat_en(ren),
        .level    (level),
        .pressed  (pressed),
        .released (released)
    );

    // Model: level flips after DEB consecutive synced samples disagreeing with it; repeat pulses
    // are placed by elapsed time since the press, as long as repeat_en stayed high throughout.
    int            now = 0;
    logic [CH-1:0] d1, d2;
    logic [CH-1:0] m_level, e_level, e_pressed, e_released;
    int            run     [CH];
    int            press_t [CH];
    bit            elig    [CH];

    task automatic model_step();
        if (rst) begin
            d1 = '0; d2 = '0; m_level = '0;
            e_level = '0; e_pressed = '0; e_released = '0;
            for (int c = 0; c < CH; c++) begin
                run[c] = 0; press_t[c] = 0; elig[c] = 0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                bit rise, fall;
                int age;
                rise = 0; fall = 0;
                if (d2[c] != m_level[c]) begin
                    run[c]++;
                    if (run[c] == int'(DEB)) begin
                        m_level[c] = d2[c];
                        run[c] = 0;
                        rise = d2[c];
                        fall = !d2[c];
                    end
                end else begin
                    run[c] = 0;
                end
                e_pressed[c]  = 1'b0;
                e_released[c] = fall;
                if (rise) begin
                    press_t[c]   = now;
                    elig[c]      = ren[c];
                    e_pressed[c] = 1'b1;
                end else if (m_level[c]) begin
                    elig[c] = elig[c] && ren[c];
                    age = now - press_t[c];
                    if (elig[c] && (age == int'(RD) ||
                                    (age > int'(RD) && (age - int'(RD)) % int'(RR) == 0)))
                        e_pressed[c] = 1'b1;
                end
            end
            d2 = d1;
            d1 = sig;
        end
        e_level = m_level;
        now++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic settle(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            checks++;
            if ({level, pressed, released} !== {e_level, e_pressed, e_released}) begin
                errors++;
                $display("FAIL settle t=%0d got l=%b p=%b r=%b want l=%b p=%b r=%b", now,
                         level, pressed, released, e_level, e_pressed, e_released);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sig = 4'hF; ren = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({level, pressed, released} !== 12'b0) begin
                errors++;
                $display("FAIL reset_outputs k=%0d got l=%b p=%b r=%b want all 0", k,
                         level, pressed, released);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (level !== ((k >= 6) ? 4'hF : 4'h0) || pressed !== ((k == 6) ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL reset_press edge=%0d got l=%b p=%b want l=%b p=%b", k, level,
                         pressed, (k >= 6) ? 4'hF : 4'h0, (k == 6) ? 4'hF : 4'h0);
            end
        end
        sig = '0;
        settle(10);
    endtask

    task automatic test_glitch();
        for (int k = 1; k <= 23; k++) begin
            sig[0] = (k <= 3);
            tick();
            checks++;
            if ({level[0], pressed[0], released[0]} !== 3'b000 ||
                {level, pressed, released} !== {e_level, e_pressed, e_released}) begin
                errors++;
                $display("FAIL glitch edge=%0d got l=%b p=%b r=%b want ch0 quiet", k, level,
                         pressed, released);
            end
        end
    endtask

    task automatic test_press_release();
        ren = '0;
        for (int k = 1; k <= 30; k++) begin
            sig[1] = (k <= 20);
            tick();
            checks++;
            if (pressed[1] !== (k == 6) || released[1] !== (k == 26) ||
                {level, pressed, released} !== {e_level, e_pressed, e_released}) begin
                errors++;
                $display("FAIL press_release edge=%0d got p=%b r=%b want p1=%0d r1=%0d", k,
                         pressed, released, k == 6, k == 26);
            end
        end
    endtask

    task automatic test_auto_repeat();
        ren = 4'b0100;
        for (int k = 1; k <= 42; k++) begin
            bit want_p;
            sig[2] = (k <= 31);
            tick();
            want_p = (k == 6) || (k >= 16 && k < 37 && (k - 16) % 3 == 0);
            checks++;
            if (pressed[2] !== want_p || released[2] !== (k == 37) ||
                {level, pressed, released} !== {e_level, e_pressed, e_released}) begin
                errors++;
                $display("FAIL auto_repeat edge=%0d got p=%b r=%b want p2=%0d r2=%0d", k,
                         pressed, released, want_p, k == 37);
            end
        end
        ren = '0;
    endtask

    task automatic test_repeat_disable();
        for (int k = 1; k <= 40; k++) begin
            sig[3] = (k <= 30);
            ren[3] = (k <= 17);
            tick();
            checks++;
            if (pressed[3] !== (k == 6 || k == 16) || released[3] !== (k == 36) ||
                {level, pressed, released} !== {e_level, e_pressed, e_released}) begin
                errors++;
                $display("FAIL repeat_disable edge=%0d got p=%b r=%b want p3=%0d r3=%0d", k,
                         pressed, released, k == 6 || k == 16, k == 36);
            end
        end
        ren = '0;
    endtask

    task automatic test_concurrency();
        ren = '0;
        sig = 4'b0010;
        settle(8);
        sig = 4'b0101;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (pressed !== ((k == 6) ? 4'b0101 : 4'b0000) ||
                released !== ((k == 6) ? 4'b0010 : 4'b0000) ||
                {level, pressed, released} !== {e_level, e_pressed, e_released}) begin
                errors++;
                $display("FAIL concurrency edge=%0d got p=%b r=%b want p=%b r=%b", k, pressed,
                         released, (k == 6) ? 4'b0101 : 4'b0000, (k == 6) ? 4'b0010 : 4'b0000);
            end
        end
        sig = '0;
        settle(10);
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 399) == 0);
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 3 + 8 * c) == 0) sig[c] = ~sig[c];
                if ($urandom_range(0, 29) == 0)        ren[c] = ~ren[c];
            end
            tick();
            checks++;
            if ({level, pressed, released} !== {e_level, e_pressed, e_released}) begin
                errors++;
                $display("FAIL random t=%0d got l=%b p=%b r=%b want l=%b p=%b r=%b", now,
                         level, pressed, released, e_level, e_pressed, e_released);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sig = '0;
        ren = '0;
        test_reset();
        test_glitch();
        test_press_release();
        test_auto_repeat();
        test_repeat_disable();
        test_concurrency();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
